instr_executor: RTL and testbench

Single-cycle execute stage of the 32-bit RISC core. Each instruction word fetched by the separate instruction ROM goes through a 16×32 register bank and ALU. The block computes the next program counter combinationally and commits the register write-back on a clock edge gated by a step strobe. The CPU top loads `pc <= npc` at its own step rate and stops when `halted` is asserted.

---
 rtl/instr_executor.sv | 156 +++++++++++++++
 tb/tb_instr_executor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_executor.sv
// Single-cycle execute stage: 16x32 register bank, ALU, next-PC logic and stepped write-back.
// Optional multiplier for R-type funct 9 is enabled by defining INSTR_EXEC_MUL_EN.
module instr_executor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic [31:0] npc,
    output logic        halted,
    input  logic [3:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam logic [5:0] OP_HALT  = 6'h00;
    localparam logic [5:0] OP_RTYPE = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_SLTI  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h05;
    localparam logic [5:0] OP_BNE   = 6'h06;
    localparam logic [5:0] OP_BLT   = 6'h07;
    localparam logic [5:0] OP_JMP   = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0A;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SLT = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;
    localparam logic [3:0] FN_SRA = 4'd8;
`ifdef INSTR_EXEC_MUL_EN
    localparam logic [3:0] FN_MUL = 4'd9;
`endif

    logic [5:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [3:0]  funct;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [25:0] target;

    assign op     = instruction[31:26];
    assign rs     = instruction[25:22];
    assign rt     = instruction[21:18];
    assign rd     = instruction[17:14];
    assign funct  = instruction[3:0];
    assign imm    = instruction[15:0];
    assign simm   = {{16{imm[15]}}, imm};
    assign target = instruction[25:0];

    logic [31:0] rf [16];
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] branch_target;
    logic        wr_en_next;
    logic [3:0]  wr_addr_next;
    logic [31:0] wr_data_next;
    logic [31:0] npc_next;

    // R0 is hardwired; only R1..R15 hold state.
    assign rf[0] = 32'h0;

    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_reg
            logic [31:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= 32'h0;
                end else if (step && wr_en_next && (wr_addr_next == 4'(gi))) begin
                    data_reg <= wr_data_next;
                end
            end

            assign rf[gi] = data_reg;
        end
    endgenerate

    assign rs_val        = rf[rs];
    assign rt_val        = rf[rt];
    assign dbg_data      = rf[dbg_sel];
    assign branch_target = pc + 32'd1 + simm;

    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = rt;
        wr_data_next = 32'h0;
        npc_next     = pc + 32'd1;

        case (op)
            OP_HALT: begin
                npc_next = pc;
            end
            OP_RTYPE: begin
                wr_addr_next = rd;
                wr_en_next   = 1'b1;
                case (funct)
                    FN_ADD:  wr_data_next = rs_val + rt_val;
                    FN_SUB:  wr_data_next = rs_val - rt_val;
                    FN_AND:  wr_data_next = rs_val & rt_val;
                    FN_OR:   wr_data_next = rs_val | rt_val;
                    FN_XOR:  wr_data_next = rs_val ^ rt_val;
                    FN_SLT:  wr_data_next = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL:  wr_data_next = rs_val << rt_val[4:0];
                    FN_SRL:  wr_data_next = rs_val >> rt_val[4:0];
                    FN_SRA:  wr_data_next = $unsigned($signed(rs_val) >>> rt_val[4:0]);
`ifdef INSTR_EXEC_MUL_EN
                    FN_MUL:  wr_data_next = rs_val * rt_val;
`endif
                    default: wr_en_next = 1'b0;
                endcase
            end
            OP_ADDI: begin
                wr_en_next   = 1'b1;
                wr_data_next = rs_val + simm;
            end
            OP_SLTI: begin
                wr_en_next   = 1'b1;
                wr_data_next = {31'h0, $signed(rs_val) < $signed(simm)};
            end
            OP_BEQ: begin
                if (rs_val == rt_val) npc_next = branch_target;
            end
            OP_BNE: begin
                if (rs_val != rt_val) npc_next = branch_target;
            end
            OP_BLT: begin
                if ($signed(rs_val) < $signed(rt_val)) npc_next = branch_target;
            end
            OP_JMP: begin
                npc_next = {6'b0, target};
            end
            OP_LUI: begin
                wr_en_next   = 1'b1;
                wr_data_next = {imm, 16'h0};
            end
            OP_ORI: begin
                wr_en_next   = 1'b1;
                wr_data_next = rs_val | {16'h0, imm};
            end
            default: begin
                // NOP and unassigned opcodes fall through with no write.
            end
        endcase
    end

    assign npc    = npc_next;
    assign halted = (op == OP_HALT);

endmodule

// File: tb/tb_instr_executor.sv
// Directed self-checking bench for instr_executor; honours INSTR_EXEC_MUL_EN for the multiply case.
module tb_instr_executor;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] npc;
    logic        halted;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_data;

    int checks_cnt = 0;
    int errors_cnt = 0;

    instr_executor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step),
        .pc          (pc),
        .instruction (instruction),
        .npc         (npc),
        .halted      (halted),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: got %h", tag, got);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [3:0] rs, input logic [3:0] rt,
                                          input logic [3:0] rd, input logic [3:0] fn);
        return {6'h01, rs, rt, rd, 10'h0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rs,
                                          input logic [3:0] rt, input logic [15:0] imm);
        return {op, rs, rt, 2'b00, imm};
    endfunction

    task automatic exec(input logic [31:0] instr, input logic do_step);
        instruction = instr;
        step        = do_step;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        dbg_sel = sel;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        step        = 1'b0;
        pc          = 32'd5;
        instruction = 32'h0;
        dbg_sel     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_halted", {31'h0, halted}, 32'd1);
        check("rst_npc_halt", npc, 32'd5);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk_reg($sformatf("rst_r%0d", i), 4'(i), 32'h0);
        end

        // Immediates, R0 and R-type ALU ops
        pc = 32'd20;
        exec(enc_i(6'h02, 4'd0, 4'd1, 16'd5), 1'b1);
        exec(enc_i(6'h02, 4'd0, 4'd2, 16'hFFFD), 1'b1);
        chk_reg("addi_r1", 4'd1, 32'd5);
        chk_reg("addi_r2", 4'd2, 32'hFFFF_FFFD);
        exec(enc_r(4'd1, 4'd2, 4'd3, 4'd0), 1'b1);
        chk_reg("add_r3", 4'd3, 32'd2);
        exec(enc_r(4'd2, 4'd1, 4'd4, 4'd1), 1'b1);
        chk_reg("sub_r4", 4'd4, 32'hFFFF_FFF8);
        exec(enc_i(6'h02, 4'd0, 4'd0, 16'd7), 1'b1);
        chk_reg("r0_zero", 4'd0, 32'h0);
        exec(enc_r(4'd1, 4'd2, 4'd5, 4'd2), 1'b1);
        chk_reg("and_r5", 4'd5, 32'd5);
        exec(enc_r(4'd1, 4'd4, 4'd6, 4'd3), 1'b1);
        chk_reg("or_r6", 4'd6, 32'hFFFF_FFFD);
        exec(enc_r(4'd1, 4'd2, 4'd7, 4'd4), 1'b1);
        chk_reg("xor_r7", 4'd7, 32'hFFFF_FFF8);
        exec(enc_r(4'd2, 4'd1, 4'd8, 4'd5), 1'b1);
        chk_reg("slt_true", 4'd8, 32'd1);
        exec(enc_r(4'd1, 4'd2, 4'd9, 4'd5), 1'b1);
        chk_reg("slt_false", 4'd9, 32'd0);
        exec(enc_r(4'd1, 4'd1, 4'd10, 4'd6), 1'b1);
        chk_reg("sll_r10", 4'd10, 32'h0000_00A0);
        exec(enc_r(4'd2, 4'd3, 4'd11, 4'd7), 1'b1);
        chk_reg("srl_r11", 4'd11, 32'h3FFF_FFFF);
        exec(enc_r(4'd2, 4'd3, 4'd12, 4'd8), 1'b1);
        chk_reg("sra_r12", 4'd12, 32'hFFFF_FFFF);
        exec(enc_i(6'h03, 4'd2, 4'd13, 16'hFFFE), 1'b1);
        chk_reg("slti_r13", 4'd13, 32'd1);
        exec(enc_i(6'h09, 4'd0, 4'd14, 16'h1234), 1'b1);
        chk_reg("lui_r14", 4'd14, 32'h1234_0000);
        exec(enc_i(6'h0A, 4'd14, 4'd14, 16'h00F0), 1'b1);
        chk_reg("ori_r14", 4'd14, 32'h1234_00F0);
        exec(enc_r(4'd1, 4'd1, 4'd1, 4'd0), 1'b1);
        chk_reg("add_self_r1", 4'd1, 32'd10);
        exec(enc_r(4'd1, 4'd2, 4'd3, 4'd10), 1'b1);
        chk_reg("bad_funct_r3", 4'd3, 32'd2);

        // Branches at pc = 10
        exec(enc_i(6'h02, 4'd0, 4'd1, 16'd4), 1'b1);
        exec(enc_i(6'h02, 4'd0, 4'd5, 16'd4), 1'b1);
        pc = 32'd10;
        instruction = enc_i(6'h05, 4'd1, 4'd5, 16'hFFFD);
        #1;
        check("beq_taken", npc, 32'd8);
        check("beq_not_halted", {31'h0, halted}, 32'd0);
        instruction = enc_i(6'h06, 4'd1, 4'd5, 16'hFFFD);
        #1;
        check("bne_not_taken", npc, 32'd11);
        instruction = enc_i(6'h05, 4'd1, 4'd2, 16'hFFFD);
        #1;
        check("beq_not_taken", npc, 32'd11);
        exec(enc_i(6'h02, 4'd0, 4'd1, 16'hFFFF), 1'b1);
        exec(enc_i(6'h02, 4'd0, 4'd2, 16'd2), 1'b1);
        instruction = enc_i(6'h07, 4'd1, 4'd2, 16'd5);
        #1;
        check("blt_taken", npc, 32'd16);
        instruction = enc_i(6'h07, 4'd2, 4'd1, 16'd5);
        #1;
        check("blt_not_taken", npc, 32'd11);
        instruction = enc_i(6'h06, 4'd1, 4'd2, 16'hFFF0);
        #1;
        check("bne_taken", npc, 32'hFFFF_FFFB);

        // Hold, jump, NOP, unknown opcode, stepped HALT
        instruction = enc_i(6'h02, 4'd0, 4'd1, 16'd9);
        #1;
        check("hold_npc", npc, 32'd11);
        exec(enc_i(6'h02, 4'd0, 4'd1, 16'd9), 1'b0);
        chk_reg("hold_r1", 4'd1, 32'hFFFF_FFFF);
        instruction = {6'h08, 26'h40};
        #1;
        check("jmp_npc", npc, 32'h40);
        exec(32'h1000_0000, 1'b1);
        chk_reg("nop_r2", 4'd2, 32'd2);
        exec(enc_i(6'h3F, 4'd0, 4'd2, 16'h55), 1'b1);
        chk_reg("badop_r2", 4'd2, 32'd2);
        instruction = 32'h0;
        #1;
        check("halt_npc", npc, 32'd10);
        exec(32'h0, 1'b1);
        chk_reg("halt_step_r2", 4'd2, 32'd2);

        // Multiply
        exec(enc_i(6'h02, 4'd0, 4'd1, 16'd7), 1'b1);
        exec(enc_i(6'h02, 4'd0, 4'd2, 16'hFFFA), 1'b1);
        exec(enc_r(4'd1, 4'd2, 4'd3, 4'd9), 1'b1);
`ifdef INSTR_EXEC_MUL_EN
        chk_reg("mul_r3", 4'd3, 32'hFFFF_FFD6);
`else
        chk_reg("mul_r3", 4'd3, 32'd2);
`endif

        // Reset mid-step discards pending write
        @(negedge clk);
        instruction = enc_i(6'h02, 4'd0, 4'd1, 16'd5);
        step        = 1'b1;
        #1;
        rst_n = 1'b0;
        chk_reg("midrst_r1_async", 4'd1, 32'h0);
        chk_reg("midrst_r7_async", 4'd7, 32'h0);
        @(posedge clk);
        #1;
        step  = 1'b0;
        rst_n = 1'b1;
        chk_reg("midrst_r1_after", 4'd1, 32'h0);
        exec(enc_i(6'h02, 4'd0, 4'd1, 16'd5), 1'b1);
        chk_reg("post_rst_addi_r1", 4'd1, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
